// File: rtl/zbb_wb_stage_if.sv
// Execute-to-writeback handshake bundle: the execute stage drives the
// instruction results, the writeback register answers with ex_ready.
interface zbb_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_alu_result;
  logic            ex_alu_we;
  logic [XLEN-1:0] ex_zbb_result;
  logic            ex_is_zbb;
  logic            ex_zbb_we;

  modport master (
    output ex_valid, ex_rd, ex_alu_result, ex_alu_we,
           ex_zbb_result, ex_is_zbb, ex_zbb_we,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_alu_result, ex_alu_we,
           ex_zbb_result, ex_is_zbb, ex_zbb_we,
    output ex_ready
  );
endinterface

// File: rtl/zbb_wb_stage.sv
// Execute-to-writeback register after the ALU/Zbb units, with register-file
// write port and one-stage forwarding. Define ZBB_WB_PERF_EN for retire counters.
module zbb_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  zbb_wb_stage_if.slave   ex_bus,
  input  logic            stall,
  input  logic            flush,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_wd,
  output logic            wb_we,
  output logic            wb_is_zbb,
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_data
`ifdef ZBB_WB_PERF_EN
  ,
  input  logic            perf_clr,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_zbb
`endif
);

  if (XLEN < 1 || CNT_W < 1) begin : g_bad_params
    $error("zbb_wb_stage: XLEN and CNT_W must be positive");
  end

  logic [XLEN-1:0] sel_data_s;
  logic            sel_we_s;
  logic            wb_valid_r;
  logic [4:0]      wb_rd_r;
  logic [XLEN-1:0] wb_wd_r;
  logic            wb_we_r;
  logic            wb_is_zbb_r;

  assign ex_bus.ex_ready = ~stall;

  // Result mux: the Zbb match flag steers both data and write request
  always_comb begin
    sel_data_s = ex_bus.ex_alu_result;
    sel_we_s   = ex_bus.ex_alu_we;
    if (ex_bus.ex_is_zbb) begin
      sel_data_s = ex_bus.ex_zbb_result;
      sel_we_s   = ex_bus.ex_zbb_we;
    end else begin
      sel_data_s = ex_bus.ex_alu_result;
      sel_we_s   = ex_bus.ex_alu_we;
    end
  end

  // Pipeline register; wb_we_r already folds in valid and the x0 suppression
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_wd_r     <= {XLEN{1'b0}};
      wb_we_r     <= 1'b0;
      wb_is_zbb_r <= 1'b0;
    end else if (flush) begin
      wb_valid_r  <= 1'b0;
      wb_we_r     <= 1'b0;
    end else if (!stall) begin
      wb_valid_r  <= ex_bus.ex_valid;
      wb_rd_r     <= ex_bus.ex_rd;
      wb_wd_r     <= sel_data_s;
      wb_we_r     <= ex_bus.ex_valid & sel_we_s & (ex_bus.ex_rd != 5'd0);
      wb_is_zbb_r <= ex_bus.ex_is_zbb;
    end
  end

  assign wb_valid    = wb_valid_r;
  assign wb_rd       = wb_rd_r;
  assign wb_wd       = wb_wd_r;
  assign wb_we       = wb_we_r;
  assign wb_is_zbb   = wb_is_zbb_r;
  assign fwd_data    = wb_wd_r;
  assign fwd_rs1_hit = wb_we_r & (fwd_rs1 == wb_rd_r);
  assign fwd_rs2_hit = wb_we_r & (fwd_rs2 == wb_rd_r);

`ifdef ZBB_WB_PERF_EN
  logic             retire_s;
  logic [CNT_W-1:0] perf_retired_r;
  logic [CNT_W-1:0] perf_zbb_r;

  // A held instruction retires only on the cycle it leaves the stage
  assign retire_s = wb_valid_r & ~stall;

  // Retire counters; clear beats a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_r <= {CNT_W{1'b0}};
      perf_zbb_r     <= {CNT_W{1'b0}};
    end else if (perf_clr) begin
      perf_retired_r <= {CNT_W{1'b0}};
      perf_zbb_r     <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      perf_retired_r <= perf_retired_r + CNT_W'(1);
      if (wb_is_zbb_r) begin
        perf_zbb_r <= perf_zbb_r + CNT_W'(1);
      end
    end
  end

  assign perf_retired = perf_retired_r;
  assign perf_zbb     = perf_zbb_r;
`endif

endmodule
